mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 156 +++++++++++++++
 tb/tb_mem_access.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Request/acknowledge memory bus between the memory-stage access unit and the data memory.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access unit: issues one aligned load/store on a req/ack bus, stalls until
// ack or timeout, and returns sign/zero-extended load data.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         rw,
  input  logic [1:0]   store_sel,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  mem_access_if.master memBus,
  output logic         stall,
  output logic         done,
  output logic [31:0]  load_data,
  output logic         misalign,
  output logic         bus_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic       MEM_WRITE = 1'b1;
  // Store width codes share the funct3[1:0] width encoding: byte=00, half=01, word=10.
  localparam logic [1:0] STORE_B   = 2'b00;
  localparam logic [1:0] STORE_H   = 2'b01;
  localparam int         CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          w_isLoad, w_isMem, w_aligned, w_start, w_timeout;
  logic [1:0]    w_sizeCode;
  logic [3:0]    w_be;
  logic [31:0]   w_lane, w_loadExt;
  logic [31:0]   r_addr, r_wdata, r_loadData;
  logic          r_rw, r_isLoad, r_misalign, r_busErr;
  logic [1:0]    r_storeSel;
  logic [2:0]    r_funct3;
  logic [CW-1:0] r_count;

  assign w_isLoad   = (opcode == OP_LOAD);
  assign w_isMem    = valid && (w_isLoad || (opcode == OP_STORE));
  assign w_sizeCode = w_isLoad ? funct3[1:0] : store_sel;

  always_comb begin
    w_aligned = 1'b1;
    case (w_sizeCode)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr[0];
      default: w_aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign w_start = w_isMem && w_aligned;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Ack is tested before the timeout so a same-cycle ack still completes the access.
  always_comb begin
    w_next         = r_state;
    w_timeout      = 1'b0;
    stall          = 1'b0;
    done           = 1'b0;
    memBus.mem_req = 1'b0;
    memBus.mem_we  = 1'b0;
    memBus.mem_be  = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          stall  = 1'b1;
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        stall          = 1'b1;
        memBus.mem_req = 1'b1;
        memBus.mem_we  = (r_rw == MEM_WRITE);
        memBus.mem_be  = w_be;
        if (memBus.mem_ack) begin
          w_next = S_DONE;
        end else if (r_count == LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_be = r_isLoad                ? 4'b1111 :
                (r_storeSel == STORE_B) ? (4'b0001 << r_addr[1:0]) :
                (r_storeSel == STORE_H) ? (4'b0011 << r_addr[1:0]) : 4'b1111;

  assign memBus.mem_addr  = {r_addr[31:2], 2'b00};
  assign memBus.mem_wdata = (r_storeSel == STORE_B) ? {4{r_wdata[7:0]}} :
                            (r_storeSel == STORE_H) ? {2{r_wdata[15:0]}} : r_wdata;

  assign w_lane = memBus.mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_loadExt = w_lane;
    case (r_funct3)
      3'b000:  w_loadExt = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_loadExt = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_loadExt = {24'd0, w_lane[7:0]};
      3'b101:  w_loadExt = {16'd0, w_lane[15:0]};
      default: w_loadExt = w_lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rw       <= 1'b0;
      r_storeSel <= '0;
      r_funct3   <= '0;
      r_isLoad   <= 1'b0;
      r_count    <= '0;
      r_loadData <= '0;
      r_misalign <= 1'b0;
      r_busErr   <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) && w_isMem && !w_aligned;
      r_busErr   <= w_timeout;
      if ((r_state == S_IDLE) && w_start) begin
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_rw       <= rw;
        r_storeSel <= store_sel;
        r_funct3   <= funct3;
        r_isLoad   <= w_isLoad;
        r_count    <= '0;
      end else if ((r_state == S_BUSY) && !memBus.mem_ack) begin
        r_count <= r_count + 1'b1;
      end
      if ((r_state == S_BUSY) && memBus.mem_ack && r_isLoad) r_loadData <= w_loadExt;
    end
  end

  assign load_data = r_loadData;
  assign misalign  = r_misalign;
  assign bus_err   = r_busErr;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model of the bus, alignment and load
// extension rules, checked against the DUT every cycle.
module tb_mem_access;

  localparam int         TIMEOUT  = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

  logic        clock, reset, valid, rw;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  storeSel;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, busErr;
  logic [31:0] loadData;

  mem_access_if memBus ();

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .valid(valid), .opcode(opcode), .funct3(funct3),
    .rw(rw), .store_sel(storeSel), .addr(addr), .wdata(wdata), .memBus(memBus),
    .stall(stall), .done(done), .load_data(loadData), .misalign(misalign), .bus_err(busErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  bit chkEn = 1'b0;
  logic        expStall, expReq, expDone, expMis, expErr, expWe, expWdataChk;
  logic [31:0] expLoad, expAddr, expWdata;
  logic [3:0]  expBe;
  int stallCycles = 0, reqCycles = 0, doneCount = 0, misCount = 0, errCount = 0;
  logic [31:0] lastAddr, lastWdata;
  logic [3:0]  lastBe;
  logic        lastWe;
  int s0, r0, d0, m0, e0;

  function automatic int sizeOf(input bit isLoad, input logic [2:0] f3, input logic [1:0] ss);
    logic [1:0] code = isLoad ? f3[1:0] : ss;
    return (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] modelBe(input bit isLoad, input int sz, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    if (isLoad) return 4'b1111;
    for (int k = 0; k < sz; k++) be[int'(a[1:0]) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] modelWdata(input int sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    int sz = sizeOf(1'b1, f3, 2'b00);
    logic [31:0] v = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(int'(a[1:0]) + k) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, then move to just after the rising edge.
  task automatic tick();
    @(negedge clock);
    if (chkEn) begin
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("mem_req", 32'(memBus.mem_req), 32'(expReq));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("misalign", 32'(misalign), 32'(expMis));
      checkOutput("bus_err", 32'(busErr), 32'(expErr));
      checkOutput("load_data", loadData, expLoad);
      if (expReq) begin
        checkOutput("mem_we", 32'(memBus.mem_we), 32'(expWe));
        checkOutput("mem_addr", memBus.mem_addr, expAddr);
        checkOutput("mem_be", 32'(memBus.mem_be), 32'(expBe));
        if (expWdataChk) checkOutput("mem_wdata", memBus.mem_wdata, expWdata);
      end else begin
        checkOutput("mem_be_idle", 32'(memBus.mem_be), 32'd0);
      end
      if (stall === 1'b1) stallCycles++;
      if (done === 1'b1) doneCount++;
      if (misalign === 1'b1) misCount++;
      if (busErr === 1'b1) errCount++;
      if (memBus.mem_req === 1'b1) begin
        reqCycles++;
        lastAddr  = memBus.mem_addr;
        lastWdata = memBus.mem_wdata;
        lastBe    = memBus.mem_be;
        lastWe    = memBus.mem_we;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic setQuiet();
    expStall = 1'b0; expReq = 1'b0; expDone = 1'b0; expMis = 1'b0; expErr = 1'b0;
  endtask

  task automatic snap();
    s0 = stallCycles; r0 = reqCycles; d0 = doneCount; m0 = misCount; e0 = errCount;
  endtask

  // ackAt/resetAt: BUSY cycle (1-based) carrying mem_ack/reset; 0 means never.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] ss,
                               input logic rwIn, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int ackAt, input int resetAt);
    bit isLoad  = (op == OP_LOAD);
    bit isMem   = isLoad || (op == OP_STORE);
    int sz      = sizeOf(isLoad, f3, ss);
    bit aligned = (int'(a[1:0]) % sz) == 0;
    bit start   = isMem && aligned;
    valid = 1'b1; opcode = op; funct3 = f3; storeSel = ss; rw = rwIn; addr = a; wdata = wd;
    memBus.mem_ack = 1'b0; memBus.mem_rdata = $urandom();
    setQuiet(); expStall = start;
    tick();
    if (!start) begin
      valid = 1'b0; setQuiet(); expMis = isMem;
      tick();
      setQuiet();
      return;
    end
    valid = 1'b1; opcode = OP_LOAD; funct3 = LW; addr = ~a | 32'h1; wdata = ~wd;
    rw = ~rwIn; storeSel = ~ss;
    expStall = 1'b1; expReq = 1'b1; expWe = rwIn; expAddr = a & 32'hFFFF_FFFC;
    expBe = modelBe(isLoad, sz, a); expWdata = modelWdata(sz, wd); expWdataChk = !isLoad;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      memBus.mem_ack   = (cyc == ackAt);
      memBus.mem_rdata = (cyc == ackAt) ? rd : $urandom();
      if (cyc == resetAt) begin reset = 1'b1; valid = 1'b0; end
      tick();
      memBus.mem_ack = 1'b0;
      if (cyc == resetAt) begin
        reset = 1'b0; setQuiet(); expLoad = '0;
        memBus.mem_ack = 1'b1; memBus.mem_rdata = rd;
        tick();
        memBus.mem_ack = 1'b0;
        tick();
        return;
      end
      if (cyc == ackAt) begin
        setQuiet(); expDone = 1'b1;
        if (isLoad) expLoad = modelLoad(f3, a, rd);
        tick();
        valid = 1'b0; setQuiet();
        return;
      end
    end
    valid = 1'b0; setQuiet(); expErr = 1'b1;
    tick();
    setQuiet();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; opcode = '0; funct3 = '0; rw = 1'b0; storeSel = '0;
    addr = '0; wdata = '0; memBus.mem_ack = 1'b0; memBus.mem_rdata = '0;
    setQuiet(); expLoad = '0; expWe = 1'b0; expAddr = '0; expBe = '0; expWdata = '0;
    expWdataChk = 1'b0; lastAddr = '0; lastWdata = '0; lastBe = '0; lastWe = 1'b0;
    tick();
    chkEn = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("model_lb", modelLoad(LB, 32'h1003, 32'h80FF_FF00), 32'hFFFF_FF80);
    checkOutput("model_sh_wdata", modelWdata(2, 32'h0000_BEEF), 32'hBEEF_BEEF);

    snap();
    applyStimulus(OP_LOAD, LB, SW, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 2, 0);
    checkOutput("lb_load_data", loadData, 32'hFFFF_FF80);
    checkOutput("lb_stall_cycles", 32'(stallCycles - s0), 32'd3);
    checkOutput("lb_done_pulses", 32'(doneCount - d0), 32'd1);

    applyStimulus(OP_STORE, LW, SH, 1'b1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1, 0);
    checkOutput("sh_be", 32'(lastBe), 32'b1100);
    checkOutput("sh_wdata", lastWdata, 32'hBEEF_BEEF);
    checkOutput("sh_we", 32'(lastWe), 32'd1);
    checkOutput("sh_addr", lastAddr, 32'h0000_2000);
    checkOutput("sh_load_kept", loadData, 32'hFFFF_FF80);

    snap();
    applyStimulus(OP_LOAD, LW, SW, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1, 0);
    checkOutput("lw_mis_pulses", 32'(misCount - m0), 32'd1);
    checkOutput("lw_mis_req", 32'(reqCycles - r0), 32'd0);
    checkOutput("lw_mis_stall", 32'(stallCycles - s0), 32'd0);

    snap();
    applyStimulus(OP_LOAD, LHU, SW, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0);
    checkOutput("to_bus_err", 32'(errCount - e0), 32'd1);
    checkOutput("to_busy_cycles", 32'(reqCycles - r0), 32'd4);
    checkOutput("to_done", 32'(doneCount - d0), 32'd0);
    checkOutput("to_load_kept", loadData, 32'hFFFF_FF80);

    snap();
    applyStimulus(OP_LOAD, LW, SW, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 2);
    checkOutput("rst_done", 32'(doneCount - d0), 32'd0);
    checkOutput("rst_bus_err", 32'(errCount - e0), 32'd0);
    checkOutput("rst_req_cycles", 32'(reqCycles - r0), 32'd2);
    checkOutput("rst_load_data", loadData, 32'h0);

    snap();
    applyStimulus(OP_STORE, LW, SW, 1'b1, 32'h0000_3000, 32'h1234_5678, 32'h0, 1, 0);
    checkOutput("sw_wdata", lastWdata, 32'h1234_5678);
    checkOutput("sw_be", 32'(lastBe), 32'b1111);
    applyStimulus(OP_LOAD, LBU, SW, 1'b0, 32'h0000_3001, 32'h0, 32'h0000_A500, 1, 0);
    checkOutput("b2b_done_pulses", 32'(doneCount - d0), 32'd2);
    checkOutput("lbu_load_data", loadData, 32'h0000_00A5);

    applyStimulus(OP_LOAD, LH, SW, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_1234, 1, 0);
    checkOutput("lh_load_data", loadData, 32'hFFFF_8001);

    snap();
    applyStimulus(OP_LOAD, LW, SW, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, TIMEOUT, 0);
    checkOutput("ackprio_load", loadData, 32'hDEAD_BEEF);
    checkOutput("ackprio_err", 32'(errCount - e0), 32'd0);

    applyStimulus(OP_STORE, LW, SB, 1'b1, 32'h0000_0007, 32'h0000_00AB, 32'h0, 3, 0);
    checkOutput("sb_be", 32'(lastBe), 32'b1000);
    checkOutput("sb_wdata", lastWdata, 32'hABAB_ABAB);

    snap();
    applyStimulus(OP_ALU, LW, SW, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 1, 0);
    applyStimulus(OP_STORE, LW, SH, 1'b1, 32'h0000_2001, 32'h0000_1111, 32'h0, 1, 0);
    checkOutput("alu_sh_req", 32'(reqCycles - r0), 32'd0);
    checkOutput("sh_mis_pulses", 32'(misCount - m0), 32'd1);

    applyStimulus(OP_LOAD, LB, SW, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_7F00, 1, 0);
    checkOutput("lb_pos_load", loadData, 32'h0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
